// File: rtl/bist_seq_controller_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bist_seq_controller_if
//  Brief    : Request/verdict and sequencing-strobe bundle between the BIST
//             sequence controller (master) and its pattern generator / MISR
//             neighbours (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface bist_seq_controller_if #(
    parameter int CNT_W = 3,
    parameter int RND_W = 2
);
    logic             start;
    logic             sig_ok;
    logic             init;
    logic             running;
    logic             toggle;
    logic             finish;
    logic             bist_end;
    logic             pass;
    logic [RND_W-1:0] round_idx;
    logic [CNT_W-1:0] pattern_cnt;

    modport master (
        input  start, sig_ok,
        output init, running, toggle, finish, bist_end, pass, round_idx, pattern_cnt
    );

    modport slave (
        output start, sig_ok,
        input  init, running, toggle, finish, bist_end, pass, round_idx, pattern_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bist_seq_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : bist_seq_controller
//  Brief    : Multi-round BIST sequencer. Each accepted start runs N_ROUNDS
//             rounds of INIT -> RUN -> FINISH, then pulses bist_end with the
//             AND of every round's MISR compare result.
//             Optional macro BIST_FAIL_STOP_EN: a failing round ends the
//             sequence immediately instead of running the remaining rounds.
//  Revision : 1.0 - initial release
// ============================================================================
module bist_seq_controller #(
    parameter int N_PATTERNS    = 8,
    parameter int INIT_CYCLES   = 2,
    parameter int N_ROUNDS      = 4,
    parameter int TOGGLE_PERIOD = 4,
    parameter int CNT_W         = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1,
    parameter int RND_W         = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    bist_seq_controller_if.master bus
);

    localparam int               c_INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_PCNT_LAST = CNT_W'(N_PATTERNS - 1);
    localparam logic [RND_W-1:0]    c_RND_LAST  = RND_W'(N_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_start_q;
    logic                r_go;
    logic [c_INIT_W-1:0] r_init_cnt;
    logic [c_INIT_W-1:0] w_init_cnt_nxt;
    logic [CNT_W-1:0]    r_pcnt;
    logic [CNT_W-1:0]    w_pcnt_nxt;
    logic [RND_W-1:0]    r_round;
    logic [RND_W-1:0]    w_round_nxt;
    logic                r_pass;
    logic                w_pass_nxt;
    logic                r_init;
    logic                r_running;
    logic                r_toggle;
    logic                r_finish;
    logic                r_bist_end;
    logic                w_accept;
    logic                w_stop;
    logic                w_toggle_nxt;

    // A start is only a rising edge seen while idle; start_q resets high so a
    // level held through reset release is not mistaken for a new request.
    assign w_accept = bus.start & ~r_start_q & (r_state == S_IDLE);

`ifdef BIST_FAIL_STOP_EN
    assign w_stop = (r_round == c_RND_LAST) | ~bus.sig_ok;
`else
    assign w_stop = (r_round == c_RND_LAST);
`endif

    // Strobe on RUN cycles whose 1-based pattern number is a multiple of the period.
    assign w_toggle_nxt = (w_state_nxt == S_RUN) &&
                          (((32'(w_pcnt_nxt) + 32'd1) % 32'(TOGGLE_PERIOD)) == 32'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and next-value logic for the phase counters and verdict.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_pcnt_nxt     = r_pcnt;
        w_round_nxt    = r_round;
        w_pass_nxt     = r_pass;
        case (r_state)
            S_IDLE: begin
                if (r_go) begin
                    w_state_nxt    = S_INIT;
                    w_init_cnt_nxt = '0;
                    w_round_nxt    = '0;
                    w_pass_nxt     = 1'b1;
                end
            end
            S_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_nxt = S_RUN;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (r_pcnt == c_PCNT_LAST) w_state_nxt = S_FINISH;
                else                       w_pcnt_nxt  = r_pcnt + 1'b1;
            end
            S_FINISH: begin
                w_pass_nxt = r_pass & bus.sig_ok;
                if (w_stop) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt    = S_INIT;
                    w_round_nxt    = r_round + 1'b1;
                    w_init_cnt_nxt = '0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, verdict and phase outputs, registered alongside the state so
    // every output lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_start_q  <= 1'b1;
            r_go       <= 1'b0;
            r_init_cnt <= '0;
            r_pcnt     <= '0;
            r_round    <= '0;
            r_pass     <= 1'b0;
            r_init     <= 1'b0;
            r_running  <= 1'b0;
            r_toggle   <= 1'b0;
            r_finish   <= 1'b0;
            r_bist_end <= 1'b0;
        end else begin
            r_start_q  <= bus.start;
            r_go       <= w_accept;
            r_init_cnt <= w_init_cnt_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_round    <= w_round_nxt;
            r_pass     <= w_pass_nxt;
            r_init     <= (w_state_nxt == S_INIT);
            r_running  <= (w_state_nxt == S_RUN);
            r_toggle   <= w_toggle_nxt;
            r_finish   <= (w_state_nxt == S_FINISH);
            r_bist_end <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.init        = r_init;
    assign bus.running     = r_running;
    assign bus.toggle      = r_toggle;
    assign bus.finish      = r_finish;
    assign bus.bist_end    = r_bist_end;
    assign bus.pass        = r_pass;
    assign bus.round_idx   = r_round;
    assign bus.pattern_cnt = r_pcnt;

endmodule
`default_nettype wire
